// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong buffer turning bit-reversed FFT bins into natural order; ports clk, rst, valid_in, X_r, X_i, stall -> valid_out, Y_r, Y_i, sticky ovf; FFT_REORDER_IDX_EN adds bin_idx/sof
module fft_bitrev_reorder #(
  parameter int DATA_WIDTH = 12,
  parameter int LOG2_N = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] X_r,
  input  logic [DATA_WIDTH-1:0] X_i,
  input  logic                  stall,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] Y_r,
  output logic [DATA_WIDTH-1:0] Y_i,
`ifdef FFT_REORDER_IDX_EN
  output logic [LOG2_N-1:0]     bin_idx,
  output logic                  sof,
`else
`endif
  output logic                  ovf
);
  localparam int N = 1 << LOG2_N;
  logic [2*DATA_WIDTH-1:0] mem [2*N];
  logic [1:0] full, full_nxt;
  logic wb, rb, wr, rd, wlast, rlast;
  logic [LOG2_N-1:0] wcnt, rcnt, wadr;
  assign wr = valid_in && !full[wb];
  assign rd = full[rb] && (!stall || !valid_out);
  assign wlast = wr && (&wcnt);
  assign rlast = rd && (&rcnt);
  always_comb begin
    wadr = '0;
    for (int i = 0; i < LOG2_N; i++) wadr[i] = wcnt[LOG2_N-1-i];
    full_nxt = full;
    if (wlast) full_nxt[wb] = 1'b1;
    if (rlast) full_nxt[rb] = 1'b0;
  end
  always_ff @(posedge clk)
    if (wr) mem[{wb, wadr}] <= {X_r, X_i};
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
      wb <= 1'b0;
      rb <= 1'b0;
      wcnt <= '0;
      rcnt <= '0;
      valid_out <= 1'b0;
      Y_r <= '0;
      Y_i <= '0;
      ovf <= 1'b0;
`ifdef FFT_REORDER_IDX_EN
      bin_idx <= '0;
      sof <= 1'b0;
`else
`endif
    end else begin
      full <= full_nxt;
      if (wr) wcnt <= wcnt + 1'b1;
      if (wlast) wb <= !wb;
      if (valid_in && full[wb]) ovf <= 1'b1;
      if (rd) begin
        {Y_r, Y_i} <= mem[{rb, rcnt}];
        valid_out <= 1'b1;
        rcnt <= rcnt + 1'b1;
        if (rlast) rb <= !rb;
`ifdef FFT_REORDER_IDX_EN
        bin_idx <= rcnt;
        sof <= rcnt == '0;
`else
`endif
      end else if (!stall) begin
        valid_out <= 1'b0;
`ifdef FFT_REORDER_IDX_EN
        sof <= 1'b0;
`else
`endif
      end
    end
  end
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb_fft_bitrev_reorder: scoreboard bench for the bit-reverse reorder stage
module tb_fft_bitrev_reorder;
  logic clk = 0, rst = 1, valid_in = 0, stall = 0;
  logic [11:0] X_r = 0, X_i = 0;
  logic valid_out, ovf;
  logic [11:0] Y_r, Y_i;
`ifdef FFT_REORDER_IDX_EN
  logic [3:0] bin_idx;
  logic sof;
`endif
  typedef struct {logic [11:0] r; logic [11:0] i; logic [3:0] idx;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0, out_cnt = 0, first_cyc = 0, last_cyc = 0;
  fft_bitrev_reorder #(.DATA_WIDTH(12), .LOG2_N(4)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .X_r(X_r), .X_i(X_i), .stall(stall),
    .valid_out(valid_out), .Y_r(Y_r), .Y_i(Y_i),
`ifdef FFT_REORDER_IDX_EN
    .bin_idx(bin_idx), .sof(sof),
`endif
    .ovf(ovf));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic int bitrev(int k);
    return ((k & 1) << 3) | ((k & 2) << 1) | ((k & 4) >> 1) | ((k & 8) >> 3);
  endfunction
  function automatic logic [11:0] er(int o, int n);
    return 12'(3 * n + o);
  endfunction
  function automatic logic [11:0] ei(int o, int n);
    return 12'(-bitrev(n) - o);
  endfunction
  always @(negedge clk) begin
    if (!rst && valid_out && !stall) begin
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got Y_r=%0d Y_i=%0d, expected no output", Y_r, Y_i);
      end else begin
        e = q.pop_front();
        if (Y_r !== e.r || Y_i !== e.i) begin
          errors++;
          $display("FAIL bin_data: got %h/%h, expected %h/%h (bin %0d)", Y_r, Y_i, e.r, e.i, e.idx);
        end
`ifdef FFT_REORDER_IDX_EN
        checks++;
        if (bin_idx !== e.idx || sof !== (e.idx == 0)) begin
          errors++;
          $display("FAIL bin_idx_sof: got idx=%0d sof=%b, expected idx=%0d sof=%b", bin_idx, sof, e.idx, e.idx == 0);
        end
`endif
      end
      if (out_cnt == 0) first_cyc = cyc;
      last_cyc = cyc;
      out_cnt++;
    end
  end
  task automatic send_frame(int o, bit push, int nsamp = 16);
    if (push) for (int n = 0; n < 16; n++) q.push_back('{er(o, n), ei(o, n), 4'(n)});
    for (int k = 0; k < nsamp; k++) begin
      @(posedge clk); #1;
      valid_in = 1;
      X_r = 12'(3 * bitrev(k) + o);
      X_i = 12'(-k - o);
    end
  endtask
  task automatic end_input();
    @(posedge clk); #1;
    valid_in = 0;
  endtask
  task automatic drain(int bound);
    int c = 0;
    while ((q.size() != 0 || valid_out) && c < bound) begin
      @(posedge clk); #1;
      c++;
    end
    checks++;
    if (q.size() != 0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout: %0d bins still pending, valid_out=%b, expected 0 and 0", q.size(), valid_out);
    end
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    checks++;
    if (valid_out !== 0 || Y_r !== 0 || Y_i !== 0 || ovf !== 0) begin
      errors++;
      $display("FAIL reset_state: got v=%b Y=%h/%h ovf=%b, expected all 0", valid_out, Y_r, Y_i, ovf);
    end
    repeat (3) @(posedge clk);
    #1 checks++;
    if (valid_out !== 0) begin
      errors++;
      $display("FAIL idle_valid: got %b, expected 0", valid_out);
    end
  endtask
  task automatic test_single();
    out_cnt = 0;
    send_frame(0, 1);
    end_input();
    checks++;
    if (valid_out !== 0) begin
      errors++;
      $display("FAIL latency_early: got valid_out=%b, expected 0", valid_out);
    end
    @(posedge clk); #1;
    checks++;
    if (valid_out !== 1 || Y_r !== 0 || Y_i !== 0) begin
      errors++;
      $display("FAIL latency_bin0: got v=%b Y=%h/%h, expected 1 000/000", valid_out, Y_r, Y_i);
    end
    drain(40);
    checks++;
    if (out_cnt != 16 || last_cyc - first_cyc + 1 != 16) begin
      errors++;
      $display("FAIL single_frame: got %0d bins over %0d cycles, expected 16 over 16", out_cnt, last_cyc - first_cyc + 1);
    end
  endtask
  task automatic test_back_to_back();
    out_cnt = 0;
    send_frame(40, 1);
    send_frame(1000, 1);
    end_input();
    drain(60);
    checks++;
    if (out_cnt != 32 || last_cyc - first_cyc + 1 != 32) begin
      errors++;
      $display("FAIL back_to_back: got %0d bins over %0d cycles, expected 32 over 32", out_cnt, last_cyc - first_cyc + 1);
    end
    checks++;
    if (ovf !== 0) begin
      errors++;
      $display("FAIL b2b_ovf: got %b, expected 0", ovf);
    end
  endtask
  task automatic test_stall();
    int c = 0;
    send_frame(100, 1);
    end_input();
    while (!(valid_out && Y_r == er(100, 7)) && c < 30) begin
      @(posedge clk); #1;
      c++;
    end
    stall = 1;
    checks++;
    if (c >= 30) begin
      errors++;
      $display("FAIL stall_reach_bin7: timed out, expected bin 7 with Y_r=%0d", er(100, 7));
    end
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1;
      checks++;
      if (valid_out !== 1 || Y_r !== er(100, 7) || Y_i !== ei(100, 7)) begin
        errors++;
        $display("FAIL stall_hold: got v=%b Y=%h/%h, expected 1 %h/%h", valid_out, Y_r, Y_i, er(100, 7), ei(100, 7));
      end
    end
    stall = 0;
    @(posedge clk); #1;
    checks++;
    if (valid_out !== 1 || Y_r !== er(100, 8)) begin
      errors++;
      $display("FAIL stall_resume: got v=%b Y_r=%h, expected 1 %h", valid_out, Y_r, er(100, 8));
    end
    drain(40);
  endtask
  task automatic test_overflow();
    out_cnt = 0;
    stall = 1;
    send_frame(200, 1);
    send_frame(300, 1);
    checks++;
    if (ovf !== 0) begin
      errors++;
      $display("FAIL ovf_early: got %b, expected 0", ovf);
    end
    send_frame(400, 0);
    end_input();
    checks++;
    if (ovf !== 1 || valid_out !== 1 || Y_r !== er(200, 0)) begin
      errors++;
      $display("FAIL ovf_set: got ovf=%b v=%b Y_r=%h, expected 1 1 %h", ovf, valid_out, Y_r, er(200, 0));
    end
    repeat (3) @(posedge clk);
    #1 stall = 0;
    drain(80);
    checks++;
    if (out_cnt != 32 || ovf !== 1) begin
      errors++;
      $display("FAIL ovf_drain: got %0d bins ovf=%b, expected 32 and 1", out_cnt, ovf);
    end
  endtask
  task automatic test_mid_reset();
    send_frame(500, 0, 9);
    @(posedge clk); #1;
    valid_in = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    checks++;
    if (valid_out !== 0 || Y_r !== 0 || ovf !== 0) begin
      errors++;
      $display("FAIL mid_reset_state: got v=%b Y_r=%h ovf=%b, expected 0 0 0", valid_out, Y_r, ovf);
    end
    out_cnt = 0;
    repeat (20) @(posedge clk);
    #1 checks++;
    if (out_cnt != 0 || valid_out !== 0) begin
      errors++;
      $display("FAIL partial_frame: got %0d bins, expected 0", out_cnt);
    end
    send_frame(600, 1);
    end_input();
    drain(40);
    checks++;
    if (out_cnt != 16) begin
      errors++;
      $display("FAIL post_reset_frame: got %0d bins, expected 16", out_cnt);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_mid_reset();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
